// File: rtl/mmc_secbuf_pkg.sv
// Shared definitions for the MMC sector buffer.
// SECTOR_BYTES : bytes in one sector (512).
// ADDR_W       : byte index width within one sector.
// DATA_W       : byte width.
// core_state_e : encoding of the core-side access FSM.
package mmc_secbuf_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_ACK    = 2'd2
  } core_state_e;

endpackage

// File: rtl/mmc_secbuf_if.sv
// Bus bundle between the core, the MMC controller and the sector buffer.
// master : the side that issues core requests and drives the controller port
//          (CORE_REQ/WE/ADDR/D, MMC_READY/ADDR/D/WE out; CORE_Q/ACK, MMC_Q,
//          DIRTY in).
// slave  : the sector buffer itself (directions reversed).
interface mmc_secbuf_if #(
  parameter int ADDR_W = mmc_secbuf_pkg::ADDR_W,
  parameter int DATA_W = mmc_secbuf_pkg::DATA_W
);

  logic              CORE_REQ;
  logic              CORE_WE;
  logic [ADDR_W-1:0] CORE_ADDR;
  logic [DATA_W-1:0] CORE_D;
  logic [DATA_W-1:0] CORE_Q;
  logic              CORE_ACK;
  logic              MMC_READY;
  logic [ADDR_W-1:0] MMC_ADDR;
  logic [DATA_W-1:0] MMC_D;
  logic              MMC_WE;
  logic [DATA_W-1:0] MMC_Q;
  logic              DIRTY;

  modport master (
    output CORE_REQ, CORE_WE, CORE_ADDR, CORE_D,
    output MMC_READY, MMC_ADDR, MMC_D, MMC_WE,
    input  CORE_Q, CORE_ACK, MMC_Q, DIRTY
  );

  modport slave (
    input  CORE_REQ, CORE_WE, CORE_ADDR, CORE_D,
    input  MMC_READY, MMC_ADDR, MMC_D, MMC_WE,
    output CORE_Q, CORE_ACK, MMC_Q, DIRTY
  );

endinterface

// File: rtl/mmc_secbuf_ram.sv
// True dual-port sector RAM, 2^ADDR_W x DATA_W, synchronous read on both ports.
// i_clk            : clock
// i_a_we/addr/d    : port A (core side) write enable, address, write data
// o_a_q            : port A read data, 1 cycle after i_a_addr
// i_b_we/addr/d    : port B (controller side) write enable, address, data
// o_b_q            : port B read data, 1 cycle after i_b_addr
// Reads return the contents before any write at the same edge. When both
// ports write the same address in one cycle, port B's data is kept.
module mmc_secbuf_ram #(
  parameter int ADDR_W = mmc_secbuf_pkg::ADDR_W,
  parameter int DATA_W = mmc_secbuf_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_d,
  output logic [DATA_W-1:0] o_a_q,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_d,
  output logic [DATA_W-1:0] o_b_q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_a_q;
  logic [DATA_W-1:0] r_b_q;
  logic              w_a_we;

  // Suppress the port A write on a same-address collision so port B wins
  // without relying on assignment order.
  assign w_a_we = i_a_we && !(i_b_we && (i_a_addr == i_b_addr));

  always_ff @(posedge i_clk) begin
    if (w_a_we) r_mem[i_a_addr] <= i_a_d;
    if (i_b_we) r_mem[i_b_addr] <= i_b_d;
    r_a_q <= r_mem[i_a_addr];
    r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_q = r_a_q;
  assign o_b_q = r_b_q;

endmodule

// File: rtl/mmc_secbuf.sv
// MMC sector buffer: one 512-byte sector shared between a byte-wide core
// request/ack port and the MMC controller's buffer port.
// CLK : system clock
// RST : asynchronous active-high reset
// bus : mmc_secbuf_if.slave carrying
//       CORE_REQ/WE/ADDR/D in, CORE_Q/CORE_ACK out  (core access port)
//       MMC_READY/ADDR/D/WE in, MMC_Q out            (controller port)
//       DIRTY out  (sector modified by the core since the last reload)
module mmc_secbuf
  import mmc_secbuf_pkg::*;
#(
  parameter int ADDR_W = mmc_secbuf_pkg::ADDR_W,
  parameter int DATA_W = mmc_secbuf_pkg::DATA_W
) (
  input  logic          CLK,
  input  logic          RST,
  mmc_secbuf_if.slave   bus
);

  core_state_e       r_state;
  core_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_core_q;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_dirty;
  logic              r_mmc_q_vld;

  logic              w_accept;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic              w_core_ack;
  logic [ADDR_W-1:0] w_a_addr;
  logic [DATA_W-1:0] w_a_q;
  logic [DATA_W-1:0] w_b_q;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; once accepted, a transaction runs to ACK regardless
  // of MMC_READY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.CORE_REQ && bus.MMC_READY)
          w_state_nxt = bus.CORE_WE ? ST_ACK : ST_RDWAIT;
      end
      ST_RDWAIT: w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    w_accept    = 1'b0;
    w_wr_accept = 1'b0;
    w_rd_accept = 1'b0;
    w_core_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept    = bus.CORE_REQ && bus.MMC_READY;
        w_wr_accept = w_accept && bus.CORE_WE;
        w_rd_accept = w_accept && !bus.CORE_WE;
      end
      ST_ACK:  w_core_ack = 1'b1;
      default: ;
    endcase
  end

  // Read address is held after accept so port A keeps pointing at the
  // requested byte even if the core changes CORE_ADDR.
  always_ff @(posedge CLK) begin
    if (w_rd_accept) r_rd_addr <= bus.CORE_ADDR;
  end

  assign w_a_addr = (r_state == ST_IDLE) ? bus.CORE_ADDR : r_rd_addr;

  // Port A data registered at the accept edge is captured in RDWAIT; that
  // snapshot predates any controller write at the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                     r_core_q <= '0;
    else if (r_state == ST_RDWAIT) r_core_q <= w_a_q;
  end

  // A core write accept outranks a controller reload in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              r_dirty <= 1'b0;
    else if (w_wr_accept) r_dirty <= 1'b1;
    else if (bus.MMC_WE)  r_dirty <= 1'b0;
  end

  // The RAM has no reset; MMC_Q is forced to zero until the first edge
  // after reset has loaded the port B read register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_mmc_q_vld <= 1'b0;
    else     r_mmc_q_vld <= 1'b1;
  end

  mmc_secbuf_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk    (CLK),
    .i_a_we   (w_wr_accept),
    .i_a_addr (w_a_addr),
    .i_a_d    (bus.CORE_D),
    .o_a_q    (w_a_q),
    .i_b_we   (bus.MMC_WE),
    .i_b_addr (bus.MMC_ADDR),
    .i_b_d    (bus.MMC_D),
    .o_b_q    (w_b_q)
  );

  assign bus.CORE_Q   = r_core_q;
  assign bus.CORE_ACK = w_core_ack;
  assign bus.DIRTY    = r_dirty;
  assign bus.MMC_Q    = r_mmc_q_vld ? w_b_q : '0;

endmodule

// File: doc/mmc_secbuf.md
MMC_SECBUF -- requirements
Module: mmc_secbuf

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: ADDR_W, default 9, byte index within one sector (512 bytes).
REQ-003 Parameter: DATA_W, default 8, byte width.
REQ-004 Port: CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 Port: RST  in  1  asynchronous active-high reset.
REQ-006 Port: CORE_REQ  in  1  core access request; held high until CORE_ACK.
REQ-007 Port: CORE_WE  in  1  1 = byte write, 0 = byte read; sampled with CORE_REQ.
REQ-008 Port: CORE_ADDR  in  ADDR_W  byte offset in the sector.
REQ-009 Port: CORE_D  in  DATA_W  core write data.
REQ-010 Port: CORE_Q  out  DATA_W  core read data; valid while CORE_ACK=1.
REQ-011 Port: CORE_ACK  out  1  one-cycle completion pulse.
REQ-012 Port: MMC_READY  in  1  controller idle with the requested block loaded.
REQ-013 Port: MMC_ADDR  in  ADDR_W  controller-side buffer address.
REQ-014 Port: MMC_D  in  DATA_W  controller-side write data (received sector bytes).
REQ-015 Port: MMC_WE  in  1  controller-side write strobe.
REQ-016 Port: MMC_Q  out  DATA_W  controller-side read data, one cycle after MMC_ADDR.
REQ-017 Port: DIRTY  out  1  sector modified by the core since the last controller load.

Function
REQ-018 Storage SHALL be 2^ADDR_W x DATA_W with two independent ports and synchronous read on both (1-cycle latency).
REQ-019 Controller port: MMC_WE=1 writes MMC_D to MMC_ADDR at that edge; MMC_Q SHALL show mem[MMC_ADDR] registered every cycle, irrespective of MMC_READY.
REQ-020 Core FSM states: IDLE, RDWAIT, ACK.
REQ-021 IDLE: a request is accepted only when CORE_REQ=1 and MMC_READY=1; otherwise the FSM stays in IDLE.
REQ-022 Accepted write: CORE_D stored at CORE_ADDR at the accept edge, DIRTY set, next state ACK (ACK 1 cycle after accept).
REQ-023 Accepted read: address latched, next state RDWAIT; RDWAIT captures mem output into CORE_Q, next state ACK (ACK 2 cycles after accept).
REQ-024 ACK: CORE_ACK=1 for exactly one cycle, next state IDLE; CORE_Q holds its value until the next read capture.
REQ-025 The core SHALL drop CORE_REQ in the cycle CORE_ACK is seen; CORE_REQ still high in IDLE is a new request.
REQ-026 MMC_READY falling after accept SHALL NOT abort the transaction; it completes with normal latency.
REQ-027 DIRTY is cleared by any MMC_WE=1 cycle (sector reload); a core write accept in the same cycle wins (DIRTY=1).
REQ-028 Same-address writes from both ports in one cycle: MMC_D SHALL be stored.
REQ-029 Core read and MMC write to the same address in one cycle: core receives the old data.
REQ-030 CORE_ADDR wraps naturally; no out-of-range condition exists.

Reset
REQ-031 RST=1 SHALL force FSM=IDLE, CORE_ACK=0, CORE_Q=0, DIRTY=0, MMC_Q=0, asynchronously.
REQ-032 Memory contents are undefined after reset; no clear sweep.
REQ-033 Reset mid-transaction SHALL drop the transaction with no ACK; a pending write either completed at its accept edge or did not occur.

Structure
REQ-034 A shared package SHALL hold SECTOR_BYTES=512, ADDR_W, DATA_W and the FSM state encoding.
REQ-035 The dual-port array SHALL be a sub-module mmc_secbuf_ram (two sync ports, no reset); FSM and DIRTY live in mmc_secbuf.

Verification
REQ-036 Reset, MMC_READY=1, core write 0x5A to 0x000 -> ACK 1 cycle after accept, DIRTY=1; read 0x000 -> ACK 2 cycles after accept, CORE_Q=0x5A.
REQ-037 MMC_READY=0, CORE_REQ=1 for 20 cycles -> no ACK, DIRTY unchanged; MMC_READY=1 -> accepted next edge.
REQ-038 Controller writes 0x00..0xFF pattern (byte = addr[7:0]) to 0x000..0x1FF -> DIRTY=0; core read 0x1FF -> 0xFF; MMC_ADDR=0x1FF -> MMC_Q=0xFF next cycle.
REQ-039 Same cycle: core write accept 0x11 and MMC_WE 0x22 to 0x0A0 -> mem[0x0A0]=0x22, DIRTY=1.
REQ-040 Core read accepted, MMC_READY drops in RDWAIT -> ACK still on schedule with correct data.
REQ-041 RST asserted in RDWAIT -> CORE_ACK never pulses, FSM IDLE, DIRTY=0 immediately.
